// File: rtl/fir_low_freq_if.sv
// Sample-queue, coefficient-ROM and result bundle for the low-band FIR.
// The master side is upstream and ROM; the slave side is the filter.
interface fir_low_freq_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ADDR_W = 10
);
  logic                     sequencing;
  logic signed [DATA_W-1:0] lft_smpl;
  logic signed [DATA_W-1:0] rght_smpl;
  logic [ADDR_W-1:0]        coeff_addr;
  logic signed [COEF_W-1:0] coeff;
  logic signed [DATA_W-1:0] lft_out;
  logic signed [DATA_W-1:0] rght_out;
  logic                     vld;

  modport master (
    output sequencing, lft_smpl, rght_smpl, coeff,
    input  coeff_addr, lft_out, rght_out, vld
  );

  modport slave (
    input  sequencing, lft_smpl, rght_smpl, coeff,
    output coeff_addr, lft_out, rght_out, vld
  );
endinterface

// File: rtl/fir_low_freq.sv
// Stereo low-band FIR: multiply each burst sample by its ROM coefficient,
// accumulate across the burst, emit one saturated L/R pair per burst.
module fir_low_freq #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40,
  parameter int ADDR_W = 10
) (
  input logic           clk,
  input logic           rst,
  fir_low_freq_if.slave bus
);
  localparam int PW = DATA_W + COEF_W;
  localparam int GW = PW + ADDR_W;
  // Widened so a full 1024-tap burst at full scale cannot wrap.
  localparam int AW = (ACC_W > GW) ? ACC_W : GW;
  localparam int SH = COEF_W - 1;

  localparam logic signed [AW-1:0] MAXV =
    {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state;
  logic                 seq_d;
  logic                 prod_vld;
  logic signed [PW-1:0] lft_prod;
  logic signed [PW-1:0] rght_prod;
  logic signed [AW-1:0] lft_acc;
  logic signed [AW-1:0] rght_acc;

  function automatic logic signed [AW-1:0] ext(
    input logic signed [PW-1:0] p
  );
    return {{(AW-PW){p[PW-1]}}, p};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(
    input logic signed [AW-1:0] a
  );
    logic signed [AW-1:0] s;
    s = a >>> SH;
    if (s > MAXV)
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (s < MINV)
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return s[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.coeff_addr <= '0;
      seq_d          <= 1'b0;
      prod_vld       <= 1'b0;
      lft_prod       <= '0;
      rght_prod      <= '0;
    end else begin
      bus.coeff_addr <= bus.sequencing ? bus.coeff_addr + 1'b1 : '0;
      seq_d          <= bus.sequencing;
      prod_vld       <= seq_d;
      if (seq_d) begin
        lft_prod  <= bus.lft_smpl * bus.coeff;
        rght_prod <= bus.rght_smpl * bus.coeff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lft_acc      <= '0;
      rght_acc     <= '0;
      bus.lft_out  <= '0;
      bus.rght_out <= '0;
      bus.vld      <= 1'b0;
    end else begin
      bus.vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (prod_vld) begin
            lft_acc  <= ext(lft_prod);
            rght_acc <= ext(rght_prod);
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (prod_vld) begin
            lft_acc  <= lft_acc + ext(lft_prod);
            rght_acc <= rght_acc + ext(rght_prod);
          end else begin
            bus.lft_out  <= sat(lft_acc);
            bus.rght_out <= sat(rght_acc);
            bus.vld      <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_low_freq.sv
// Scoreboard bench for fir_low_freq: directed and random bursts checked
// against a plain dot-product model with saturation.
module tb_fir_low_freq;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_low_freq_if bus ();
  fir_low_freq dut (.clk(clk), .rst(rst), .bus(bus));

  logic signed [15:0] rom [1024];
  logic signed [15:0] ls [2048];
  logic signed [15:0] rs [2048];

  always @(posedge clk) bus.coeff <= rom[bus.coeff_addr];

  typedef struct {
    logic signed [15:0] l;
    logic signed [15:0] r;
    int                 cyc;
  } exp_t;
  exp_t q[$];
  exp_t me;

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic signed [15:0] satm(longint s);
    longint v;
    v = s >>> 15;
    if (v > 32767) return 16'sh7FFF;
    if (v < -32768) return 16'sh8000;
    return 16'(v);
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.vld === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_vld: got vld=1 expected none (cycle %0d)",
                 cyc);
      end else begin
        me = q.pop_front();
        check("lft_out", bus.lft_out, me.l);
        check("rght_out", bus.rght_out, me.r);
        check("vld_cycle", cyc, me.cyc);
      end
    end
  end

  // Drive one burst of n taps from ls/rs; abort_k >= 0 resets mid-burst.
  task automatic burst(int n, int abort_k);
    int     c_last;
    longint sl, sr;
    exp_t   e;
    c_last = 0;
    for (int k = 0; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k == abort_k) begin
        rst = 1'b1;
        bus.sequencing = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      bus.sequencing = (k < n);
      if (k > 0) begin
        bus.lft_smpl  = ls[k-1];
        bus.rght_smpl = rs[k-1];
      end
      if (k < n) begin
        check("coeff_addr", bus.coeff_addr, k % 1024);
        c_last = cyc;
      end
    end
    sl = 0;
    sr = 0;
    for (int k = 0; k < n; k++) begin
      sl += longint'(ls[k]) * longint'(rom[k % 1024]);
      sr += longint'(rs[k]) * longint'(rom[k % 1024]);
    end
    e.l = satm(sl);
    e.r = satm(sr);
    e.cyc = c_last + 4;
    q.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 30) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic fill_rom(int v);
    for (int i = 0; i < 1024; i++) rom[i] = 16'(v);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.sequencing = 1'b0;
    bus.lft_smpl = '0;
    bus.rght_smpl = '0;
    fill_rom(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i % 5 == 0) begin
        check("idle_vld", bus.vld, 0);
        check("idle_lft", bus.lft_out, 0);
        check("idle_rght", bus.rght_out, 0);
        check("idle_addr", bus.coeff_addr, 0);
      end
    end

    fill_rom(16'h4000);
    for (int k = 0; k < 4; k++) begin
      ls[k] = 16'sd1000;
      rs[k] = -16'sd1000;
    end
    burst(4, -1);
    @(posedge clk);
    #1;
    check("addr_cleared", bus.coeff_addr, 0);
    drain();

    fill_rom(16'h7FFF);
    for (int k = 0; k < 1021; k++) begin
      ls[k] = 16'sh7FFF;
      rs[k] = 16'sh8000;
    end
    burst(1021, -1);
    drain();

    for (int i = 0; i < 1024; i++) rom[i] = 16'(i);
    for (int k = 0; k < 8; k++) begin
      ls[k] = (k == 5) ? 16'sh7FFF : 16'sh0;
      rs[k] = '0;
    end
    burst(8, -1);
    drain();

    fill_rom(16'h4000);
    for (int k = 0; k < 4; k++) begin
      ls[k] = 16'sd1000;
      rs[k] = 16'sd1000;
    end
    burst(4, -1);
    for (int k = 0; k < 4; k++) begin
      ls[k] = 16'sd3000;
      rs[k] = -16'sd3000;
    end
    burst(4, -1);
    drain();

    for (int k = 0; k < 4; k++) begin
      ls[k] = 16'sd500;
      rs[k] = 16'sd700;
    end
    burst(4, 2);
    repeat (8) @(posedge clk);
    #1;
    check("abort_lft", bus.lft_out, 0);
    check("abort_rght", bus.rght_out, 0);
    check("abort_addr", bus.coeff_addr, 0);
    burst(4, -1);
    drain();

    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(1, 40);
      for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
      for (int k = 0; k < n; k++) begin
        ls[k] = 16'($urandom);
        rs[k] = 16'($urandom);
      end
      burst(n, -1);
      if (t % 3 == 2) drain();
    end
    drain();
    repeat (6) @(posedge clk);
    check("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
